// File: rtl/uart_rx_regs_if.sv
// CPU-side read port of the UART receiver: read strobes in, RX data/status/irq out.
interface uart_rx_regs_if;
  logic        rd_data;
  logic        rd_status;
  logic [31:0] rx_data;
  logic [31:0] status;
  logic        rx_irq;

  modport master (
    output rd_data,
    output rd_status,
    input  rx_data,
    input  status,
    input  rx_irq
  );

  modport slave (
    input  rd_data,
    input  rd_status,
    output rx_data,
    output status,
    output rx_irq
  );
endinterface

// File: rtl/uart_rx_regs.sv
// 8N1 UART receive engine with the RX data (63) and status (62) read registers.
module uart_rx_regs #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  input  logic           rx_en,
  uart_rx_regs_if.slave  bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [1:0]             sync_r;
  logic                   rx_s;
  logic [CNT_W-1:0]       clk_cnt_r;
  logic [BIT_W-1:0]       bit_cnt_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic [DATA_BITS-1:0]   byte_r;
  logic                   rx_valid_r;
  logic                   overrun_r;
  logic                   frame_err_r;
  logic                   rx_irq_r;
  logic                   cnt_clr_s;
  logic                   bit_clr_s;
  logic                   shift_s;
  logic                   accept_s;
  logic                   ferr_set_s;

  assign rx_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous serial line; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx};
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a low rx_en forces IDLE from any state.
  always_comb begin
    state_nxt_s = state_r;
    if (!rx_en) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!rx_s) state_nxt_s = ST_START;
          else       state_nxt_s = ST_IDLE;
        end
        ST_START: begin
          if (clk_cnt_r == HALF_LAST) state_nxt_s = rx_s ? ST_IDLE : ST_DATA;
          else                        state_nxt_s = ST_START;
        end
        ST_DATA: begin
          if (clk_cnt_r == BIT_LAST && bit_cnt_r == LAST_BIT) state_nxt_s = ST_STOP;
          else                                                 state_nxt_s = ST_DATA;
        end
        ST_STOP: begin
          if (clk_cnt_r == BIT_LAST) state_nxt_s = rx_s ? ST_IDLE : ST_WAIT_HIGH;
          else                       state_nxt_s = ST_STOP;
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state_nxt_s = ST_IDLE;
          else      state_nxt_s = ST_WAIT_HIGH;
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Datapath controls decoded from the current state and counters.
  always_comb begin
    cnt_clr_s  = 1'b0;
    bit_clr_s  = 1'b0;
    shift_s    = 1'b0;
    accept_s   = 1'b0;
    ferr_set_s = 1'b0;
    if (!rx_en) begin
      cnt_clr_s = 1'b1;
      bit_clr_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_clr_s = 1'b1;
          bit_clr_s = 1'b1;
        end
        ST_START: begin
          if (clk_cnt_r == HALF_LAST) cnt_clr_s = 1'b1;
          else                        cnt_clr_s = 1'b0;
        end
        ST_DATA: begin
          if (clk_cnt_r == BIT_LAST) begin
            shift_s   = 1'b1;
            cnt_clr_s = 1'b1;
          end else begin
            shift_s   = 1'b0;
          end
        end
        ST_STOP: begin
          if (clk_cnt_r == BIT_LAST) begin
            cnt_clr_s  = 1'b1;
            accept_s   = rx_s;
            ferr_set_s = ~rx_s;
          end else begin
            cnt_clr_s  = 1'b0;
          end
        end
        ST_WAIT_HIGH: cnt_clr_s = 1'b1;
        default: begin
          cnt_clr_s = 1'b1;
          bit_clr_s = 1'b1;
        end
      endcase
    end
  end

  // Bit-timing counter, bit counter and LSB-first shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt_r <= {CNT_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      shift_r   <= {DATA_BITS{1'b0}};
    end else begin
      clk_cnt_r <= cnt_clr_s ? {CNT_W{1'b0}} : clk_cnt_r + CNT_W'(1);
      if (bit_clr_s)    bit_cnt_r <= {BIT_W{1'b0}};
      else if (shift_s) bit_cnt_r <= bit_cnt_r + BIT_W'(1);
      if (shift_s)      shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
    end
  end

  // CPU-visible registers; a set event outranks a same-cycle read clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_r      <= {DATA_BITS{1'b0}};
      rx_valid_r  <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      rx_irq_r    <= 1'b0;
    end else begin
      rx_irq_r <= rx_valid_r;
      if (accept_s && (!rx_valid_r || bus.rd_data)) byte_r <= shift_r;
      if (accept_s)          rx_valid_r <= 1'b1;
      else if (bus.rd_data)  rx_valid_r <= 1'b0;
      if (accept_s && rx_valid_r && !bus.rd_data) overrun_r <= 1'b1;
      else if (bus.rd_status)                     overrun_r <= 1'b0;
      if (ferr_set_s)         frame_err_r <= 1'b1;
      else if (bus.rd_status) frame_err_r <= 1'b0;
    end
  end

  assign bus.rx_data = {{(32 - DATA_BITS){1'b0}}, byte_r};
  assign bus.status  = {28'd0, (state_r != ST_IDLE), frame_err_r, overrun_r, rx_valid_r};
  assign bus.rx_irq  = rx_irq_r;

endmodule

// File: tb/tb_uart_rx_regs.sv
// Directed self-checking bench for uart_rx_regs at CLKS_PER_BIT=16.
module tb_uart_rx_regs;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic rx_en;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   vcyc;
  int   icyc;

  uart_rx_regs_if bus_if ();

  uart_rx_regs #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_en (rx_en),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd_data();
    bus_if.rd_data = 1'b1;
    tick(1);
    bus_if.rd_data = 1'b0;
  endtask

  task automatic pulse_rd_status();
    bus_if.rd_status = 1'b1;
    tick(1);
    bus_if.rd_status = 1'b0;
  endtask

  // Start bit driven just after edge 0; cycle n is the n-th edge after that.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int rd_at,
                            input int stop_at, output int valid_cyc, output int irq_cyc);
    valid_cyc = -1;
    irq_cyc   = -1;
    rx = 1'b0;
    for (int cyc = 1; cyc <= 10 * CPB; cyc++) begin
      @(posedge clk);
      #1;
      if (valid_cyc < 0 && bus_if.status[0] === 1'b1) valid_cyc = cyc;
      if (irq_cyc < 0 && bus_if.rx_irq === 1'b1) irq_cyc = cyc;
      bus_if.rd_data = (cyc == rd_at);
      if (stop_at != 0 && cyc == stop_at) return;
      if (cyc < CPB)           rx = 1'b0;
      else if (cyc < 9 * CPB)  rx = data[cyc / CPB - 1];
      else                     rx = stop_bit;
    end
  endtask

  initial begin
    reset = 1'b1;
    rx = 1'b1;
    rx_en = 1'b1;
    bus_if.rd_data = 1'b0;
    bus_if.rd_status = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_rx_data", bus_if.rx_data, 32'h0);
    check("reset_status", bus_if.status, 32'h0);
    check("reset_irq", {31'd0, bus_if.rx_irq}, 32'h0);

    // 0xA5: latency and irq delay
    send_frame(8'hA5, 1'b1, 0, 0, vcyc, icyc);
    check("a5_latency", vcyc, 32'd155);
    check("a5_irq_latency", icyc, 32'd156);
    check("a5_rx_data", bus_if.rx_data, 32'h000000A5);
    check("a5_status", bus_if.status, 32'h1);
    check("a5_irq", {31'd0, bus_if.rx_irq}, 32'h1);
    pulse_rd_data();
    check("a5_read_status", bus_if.status, 32'h0);
    tick(1);
    check("a5_irq_clear", {31'd0, bus_if.rx_irq}, 32'h0);

    // 0x3C then read, then 0x7E
    send_frame(8'h3C, 1'b1, 0, 0, vcyc, icyc);
    check("3c_rx_data", bus_if.rx_data, 32'h3C);
    pulse_rd_data();
    check("3c_read_status", bus_if.status, 32'h0);
    check("3c_read_data_kept", bus_if.rx_data, 32'h3C);
    send_frame(8'h7E, 1'b1, 0, 0, vcyc, icyc);
    check("7e_rx_data", bus_if.rx_data, 32'h7E);
    check("7e_status", bus_if.status, 32'h1);
    pulse_rd_data();

    // overrun: 0x11 then 0x22 unread
    send_frame(8'h11, 1'b1, 0, 0, vcyc, icyc);
    send_frame(8'h22, 1'b1, 0, 0, vcyc, icyc);
    check("ovr_rx_data", bus_if.rx_data, 32'h11);
    check("ovr_status", bus_if.status, 32'h3);
    pulse_rd_status();
    check("ovr_after_rd_status", bus_if.status, 32'h1);
    pulse_rd_data();
    check("ovr_after_rd_data", bus_if.status, 32'h0);

    // read strobe coincident with the accept cycle
    send_frame(8'h5A, 1'b1, 0, 0, vcyc, icyc);
    send_frame(8'h99, 1'b1, 154, 0, vcyc, icyc);
    check("same_cycle_rx_data", bus_if.rx_data, 32'h99);
    check("same_cycle_status", bus_if.status, 32'h1);
    pulse_rd_data();

    // framing error with line stuck low
    send_frame(8'h55, 1'b0, 0, 0, vcyc, icyc);
    tick(50);
    check("ferr_wait_high_status", bus_if.status, 32'hC);
    check("ferr_rx_data_kept", bus_if.rx_data, 32'h99);
    rx = 1'b1;
    tick(4);
    check("ferr_idle_status", bus_if.status, 32'h4);
    send_frame(8'h0F, 1'b1, 0, 0, vcyc, icyc);
    check("0f_rx_data", bus_if.rx_data, 32'h0F);
    check("0f_status", bus_if.status, 32'h5);
    pulse_rd_status();
    check("0f_after_rd_status", bus_if.status, 32'h1);
    pulse_rd_data();

    // 3-cycle glitch: false start
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3);
    check("glitch_busy", bus_if.status, 32'h8);
    tick(6);
    check("glitch_idle", bus_if.status, 32'h0);

    // reset during data bit 4 of 0xFF
    send_frame(8'hFF, 1'b1, 0, 5 * CPB + 5, vcyc, icyc);
    check("abort_busy", bus_if.status, 32'h8);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rx = 1'b1;
    check("reset_abort_status", bus_if.status, 32'h0);
    check("reset_abort_rx_data", bus_if.rx_data, 32'h0);
    tick(2);
    send_frame(8'h81, 1'b1, 0, 0, vcyc, icyc);
    check("81_rx_data", bus_if.rx_data, 32'h81);
    check("81_status", bus_if.status, 32'h1);
    pulse_rd_data();

    // rx_en dropped during data bit 4 of 0xFF
    send_frame(8'hFF, 1'b1, 0, 5 * CPB + 5, vcyc, icyc);
    rx_en = 1'b0;
    tick(1);
    check("en_abort_status", bus_if.status, 32'h0);
    check("en_abort_rx_data", bus_if.rx_data, 32'h81);
    rx = 1'b1;
    tick(2);
    rx_en = 1'b1;
    tick(2);
    send_frame(8'h42, 1'b1, 0, 0, vcyc, icyc);
    check("42_rx_data", bus_if.rx_data, 32'h42);
    check("42_status", bus_if.status, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
